// File: rtl/pc_sequencer_pkg.sv
// Shared constants and types for the PC sequencer.
// Jump-select encoding, state encoding and datapath width.
package pc_sequencer_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] JMP_SEQ = 2'b00;
  localparam logic [1:0] JMP_J   = 2'b01;
  localparam logic [1:0] JMP_JR  = 2'b10;
  localparam logic [1:0] JMP_ILL = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_HALT = 2'b01,
    ST_TRAP = 2'b10
  } state_e;

  function automatic logic word_aligned(
    input logic [XLEN-1:0] a
  );
    return a[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/pc_sequencer_ras.sv
// Circular return-address stack with sticky over/underflow.
// A full push drops the oldest entry; an empty pop is a no-op.
module ras_stack
  import pc_sequencer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic            replace,
  input  logic [XLEN-1:0] data,
  output logic [XLEN-1:0] top,
  output logic            valid,
  output logic            overflow,
  output logic            underflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [XLEN-1:0] mem_d [DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d, ptr_inc;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            empty, full;

  assign empty   = cnt_q == '0;
  assign full    = cnt_q == CW'(DEPTH);
  assign ptr_inc = ptr_q + 1'b1;

  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    // replace on an empty stack degenerates to a push
    if (push || (replace && empty)) begin
      ptr_d          = ptr_inc;
      mem_d[ptr_inc] = data;
      if (full) ovf_d = 1'b1;
      else      cnt_d = cnt_q + 1'b1;
    end else if (replace) begin
      mem_d[ptr_q] = data;
    end else if (pop) begin
      if (empty) begin
        unf_d = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
        ptr_d = ptr_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '{default: '0};
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign valid     = !empty;
  assign top       = empty ? '0 : mem_q[ptr_q];
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: rtl/pc_sequencer.sv
// Architectural PC register, return-address stack and trap logic.
// All outputs are driven from flops; inputs only steer next state.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_next,
  input  logic [1:0]  jump,
  input  logic        link,
  input  logic        stall,
  input  logic        halt,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] ras_target,
  output logic        ras_valid,
  output logic        ras_overflow,
  output logic        ras_underflow,
  output logic        trap,
  output logic [31:0] trap_pc,
  output logic [1:0]  state
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] trap_pc_q, trap_pc_d;
  state_e          state_q, state_d;
  logic            update, fault;
  logic            ras_push, ras_pop, ras_repl;

  assign update = (state_q == ST_RUN) && !stall;
  assign fault  = (jump == JMP_ILL) || !word_aligned(pc_next);

  always_comb begin
    pc_d      = pc_q;
    trap_pc_d = trap_pc_q;
    state_d   = state_q;
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
    ras_repl  = 1'b0;
    if (update) begin
      if (fault) begin
        state_d   = ST_TRAP;
        trap_pc_d = pc_q;
      end else begin
        pc_d     = pc_next;
        ras_push = (jump == JMP_J) && link;
        ras_pop  = (jump == JMP_JR) && !link;
        ras_repl = (jump == JMP_JR) && link;
        if (halt) state_d = ST_HALT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      trap_pc_q <= '0;
      state_q   <= ST_RUN;
    end else begin
      pc_q      <= pc_d;
      trap_pc_q <= trap_pc_d;
      state_q   <= state_d;
    end
  end

  ras_stack #(
    .DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .reset    (reset),
    .push     (ras_push),
    .pop      (ras_pop),
    .replace  (ras_repl),
    .data     (pc_plus4),
    .top      (ras_target),
    .valid    (ras_valid),
    .overflow (ras_overflow),
    .underflow(ras_underflow)
  );

  assign pc       = pc_q;
  assign pc_plus4 = pc_q + 32'd4;
  assign trap     = state_q == ST_TRAP;
  assign trap_pc  = trap_pc_q;
  assign state    = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: driver queues expectations,
// monitor pops one per cycle and compares every output.
module tb_pc_sequencer;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        vld;
    logic        ovf;
    logic        unf;
    logic        trp;
    logic [31:0] tpc;
    logic [1:0]  st;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_next;
  logic [1:0]  jump;
  logic        link, stall, halt;
  logic [31:0] pc, pc_plus4, ras_target, trap_pc;
  logic        ras_valid, ras_overflow, ras_underflow, trap;
  logic [1:0]  state;

  exp_t exp_q[$];
  exp_t e;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  pc_sequencer #(
    .RESET_PC (32'h0000_0000),
    .RAS_DEPTH(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pc_next      (pc_next),
    .jump         (jump),
    .link         (link),
    .stall        (stall),
    .halt         (halt),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .ras_target   (ras_target),
    .ras_valid    (ras_valid),
    .ras_overflow (ras_overflow),
    .ras_underflow(ras_underflow),
    .trap         (trap),
    .trap_pc      (trap_pc),
    .state        (state)
  );

  task automatic chk(input string v, input string f,
                     input logic [31:0] got, input logic [31:0] want);
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s.%s got=%h want=%h", v, f, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t x;
      x = exp_q.pop_front();
      vectors++;
      chk(x.name, "pc", pc, x.pc);
      chk(x.name, "pc_plus4", pc_plus4, x.pc + 32'd4);
      chk(x.name, "ras_target", ras_target, x.tgt);
      chk(x.name, "ras_valid", {31'd0, ras_valid}, {31'd0, x.vld});
      chk(x.name, "ras_overflow", {31'd0, ras_overflow}, {31'd0, x.ovf});
      chk(x.name, "ras_underflow", {31'd0, ras_underflow}, {31'd0, x.unf});
      chk(x.name, "trap", {31'd0, trap}, {31'd0, x.trp});
      chk(x.name, "trap_pc", trap_pc, x.tpc);
      chk(x.name, "state", {30'd0, state}, {30'd0, x.st});
    end
  end

  task automatic step(input string n, input logic r, input logic [31:0] nx,
                      input logic [1:0] j, input logic l, input logic s,
                      input logic h);
    @(negedge clk);
    reset = r; pc_next = nx; jump = j; link = l; stall = s; halt = h;
    @(posedge clk);
    e.name = n;
    exp_q.push_back(e);
  endtask

  task automatic clr();
    e.pc = 32'h0; e.tgt = 32'h0; e.vld = 0; e.ovf = 0; e.unf = 0;
    e.trp = 0; e.tpc = 32'h0; e.st = 2'b00;
  endtask

  initial begin
    reset = 1; pc_next = 0; jump = 0; link = 0; stall = 0; halt = 0;

    clr(); step("reset", 1, 32'h8, 2'b00, 0, 0, 0);
    e.pc = 32'h8;
    step("seq0", 0, 32'h8, 2'b00, 0, 0, 0);
    step("seq1", 0, 32'h8, 2'b00, 0, 0, 0);
    step("seq2", 0, 32'h8, 2'b00, 0, 0, 0);
    e.pc = 32'h10;
    step("seq10", 0, 32'h10, 2'b00, 0, 0, 0);
    e.pc = 32'h100; e.tgt = 32'h14; e.vld = 1;
    step("call", 0, 32'h100, 2'b01, 1, 0, 0);
    e.pc = 32'h14; e.tgt = 32'h0; e.vld = 0;
    step("ret", 0, 32'h14, 2'b10, 0, 0, 0);

    clr(); step("rst2", 1, 32'h0, 2'b00, 0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      e.pc = 32'(4 * i); e.tgt = 32'(4 * i); e.vld = 1;
      e.ovf = (i == 5);
      step($sformatf("push%0d", i), 0, 32'(4 * i), 2'b01, 1, 0, 0);
    end
    e.pc = 32'h30; e.tgt = 32'h10;
    step("pop1", 0, 32'h30, 2'b10, 0, 0, 0);
    e.pc = 32'h34; e.tgt = 32'hC;
    step("pop2", 0, 32'h34, 2'b10, 0, 0, 0);
    e.pc = 32'h38; e.tgt = 32'h8;
    step("pop3", 0, 32'h38, 2'b10, 0, 0, 0);
    e.pc = 32'h3C; e.tgt = 32'h0; e.vld = 0;
    step("pop4", 0, 32'h3C, 2'b10, 0, 0, 0);
    e.pc = 32'h40; e.unf = 1;
    step("pop5", 0, 32'h40, 2'b10, 0, 0, 0);
    e.pc = 32'h50; e.tgt = 32'h44; e.vld = 1;
    step("repl_empty", 0, 32'h50, 2'b10, 1, 0, 0);
    e.pc = 32'h60; e.tgt = 32'h54;
    step("repl", 0, 32'h60, 2'b10, 1, 0, 0);
    e.pc = 32'h70; e.tgt = 32'h0; e.vld = 0;
    step("pop_after_repl", 0, 32'h70, 2'b10, 0, 0, 0);

    clr(); step("rst3", 1, 32'h0, 2'b00, 0, 0, 0);
    e.pc = 32'h20;
    step("to20", 0, 32'h20, 2'b00, 0, 0, 0);
    e.trp = 1; e.tpc = 32'h20; e.st = 2'b10;
    step("misalign", 0, 32'h102, 2'b00, 0, 0, 0);
    step("trap_hold", 0, 32'h200, 2'b01, 1, 0, 0);

    clr(); step("rst4", 1, 32'h0, 2'b00, 0, 0, 0);
    e.pc = 32'h8;
    step("to8", 0, 32'h8, 2'b00, 0, 0, 0);
    e.pc = 32'h80; e.tgt = 32'hC; e.vld = 1;
    step("call2", 0, 32'h80, 2'b01, 1, 0, 0);
    step("stall1", 0, 32'h90, 2'b01, 1, 1, 0);
    step("stall2", 0, 32'h90, 2'b01, 1, 1, 0);
    step("stall_halt", 0, 32'h90, 2'b00, 0, 1, 1);
    e.trp = 1; e.tpc = 32'h80; e.st = 2'b10;
    step("illegal", 0, 32'h90, 2'b11, 0, 0, 0);

    clr(); step("rst5", 1, 32'h0, 2'b00, 0, 0, 0);
    e.pc = 32'h40; e.st = 2'b01;
    step("halt", 0, 32'h40, 2'b00, 0, 0, 1);
    step("halt_hold", 0, 32'h50, 2'b01, 1, 0, 0);
    clr(); step("rst_push", 1, 32'h100, 2'b01, 1, 0, 0);

    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got=%0d want=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Sequential consumer of the jump multiplexer's next-PC output (PC_last).
- Holds the architectural program counter and produces PC+4 for the branch path.
- Owns a small return-address stack (RAS) that supplies the register-jump target (JumpR) back to the multiplexer.
- Traps on misaligned or illegal next-PC selection.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- RAS_DEPTH, 4, number of return-address entries (power of two, ≥2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- pc_next  in  32  next-PC candidate from the jump mux (signed, treated as address bits).
- jump  in  2  the same select driving the jump mux: 00 branch/seq, 01 jump, 10 jump-register, 11 illegal.
- link  in  1  current instruction writes a return address (JAL/JALR).
- stall  in  1  hold PC and RAS this cycle.
- halt  in  1  enter HALTED after this update.
- pc  out  32  current PC.
- pc_plus4  out  32  pc + 4, mod 2^32.
- ras_target  out  32  top-of-stack return address (feeds JumpR).
- ras_valid  out  1  stack non-empty.
- ras_overflow  out  1  sticky: push while full.
- ras_underflow  out  1  sticky: pop while empty.
- trap  out  1  high while in TRAP.
- trap_pc  out  32  PC of the faulting instruction.
- state  out  2  00 RUN, 01 HALTED, 10 TRAP.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - pc = RESET_PC, state = RUN.
  - RAS empty: ras_valid = 0, ras_target = 0.
  - Sticky flags = 0, trap = 0, trap_pc = 0.
  - Reset mid-operation overrides all other inputs in that cycle.
- pc_plus4 and ras_target are combinational from registers. No input-to-output combinational path.
- An update occurs when state == RUN and stall == 0. Otherwise pc, the RAS and the flags hold.
- On update, checks are applied in priority order:
  1. jump == 11 → TRAP. trap_pc <= pc, pc holds, no RAS change.
  2. pc_next[1:0] != 0 → TRAP. trap_pc <= pc, pc holds, no RAS change.
  3. Otherwise pc <= pc_next (latency 1), and the RAS op below applies.
- RAS operations:
  - Push: jump == 01 && link. The pushed value is pc_plus4.
  - Pop: jump == 10 && !link.
  - Replace: jump == 10 && link (JALR). The top entry is overwritten with pc_plus4 and depth is unchanged. If the stack is empty, this acts as a push.
  - Push when full: the circular pointer wraps, the oldest entry is lost, depth stays RAS_DEPTH, ras_overflow <= 1.
  - Pop when empty: no change, ras_underflow <= 1. pc is still updated from pc_next.
- halt with a valid update: pc takes pc_next, then state → HALTED. HALTED and TRAP exit only via reset.
- stall together with halt: halt is ignored until an update cycle.

Decomposition:
- Shared package holds:
  - jump encoding constants JMP_SEQ = 2'b00, JMP_J = 2'b01, JMP_JR = 2'b10, JMP_ILL = 2'b11.
  - state encodings ST_RUN, ST_HALT, ST_TRAP.
  - the instruction width constant, 32.
- One natural sub-module: ras_stack.
  - Parameterised by depth.
  - Inputs: push, pop, replace, data.
  - Outputs: top, valid, overflow, underflow.
  - Circular pointer plus count.

Test Plan:
- Reset then pc_next = 0x8, jump = 00 for 3 cycles → pc = 0x0, then 0x8 on each following cycle. pc_plus4 = 0xC.
- pc = 0x10, jump = 01, link = 1, pc_next = 0x100 → pc = 0x100, ras_target = 0x14, ras_valid = 1. Next cycle jump = 10, pc_next = 0x14 → pc = 0x14, ras_valid = 0.
- 5 pushes with RAS_DEPTH = 4, return addresses 0x4, 0x8, 0xC, 0x10, 0x14 → ras_overflow = 1. Then 4 pops yield ras_target 0x14, 0x10, 0xC, 0x8. A 5th pop sets ras_underflow = 1.
- pc = 0x20, pc_next = 0x102, jump = 00 → state = TRAP, trap_pc = 0x20, pc stays 0x20. Further inputs are ignored until reset.
- stall = 1 for 2 cycles with jump = 01, link = 1 → pc and RAS unchanged. jump = 11 with stall = 0 → TRAP.
- halt = 1 with pc_next = 0x40 → pc = 0x40, state = HALTED. Reset in the same cycle as a push → pc = RESET_PC, ras_valid = 0.
